// File: rtl/io_fifo_port_pkg.sv
// Shared types and defaults for the io_fifo_port block: control FSM encoding and
// default FIFO geometry.
package io_fifo_port_pkg;

    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAck     = 2'd1,
        StRelease = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap for free.
module sync_fifo
    import io_fifo_port_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [CW-1:0] CountOne  = CW'(1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CountFull);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when its head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/io_fifo_port.sv
// Core-facing register port bridging a level request/ack handshake to a pair of
// device streams through an RX FIFO (device to core) and a TX FIFO (core to device).
module io_fifo_port
    import io_fifo_port_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_read,
    input  logic                   io_write,
    input  logic [WIDTH-1:0]       io_wdata,
    output logic [WIDTH-1:0]       io_rdata,
    output logic                   ioack,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic [$clog2(DEPTH):0] tx_count
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [WIDTH-1:0] rx_head;
    logic             tx_push, tx_pop, tx_full, tx_empty;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rx_pop  = 1'b0;
        tx_push = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A pending read blocks the write even while it is stalled.
                if (io_read) begin
                    if (!rx_empty) begin
                        rx_pop  = 1'b1;
                        rdata_d = rx_head;
                        state_d = StAck;
                    end
                end else if (io_write && !tx_full) begin
                    tx_push = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!io_read && !io_write) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign ioack    = (state_q == StAck);
    assign io_rdata = rdata_q;

    // Let the device refill a full RX on the same edge the core drains it.
    assign in_ready  = ~rx_full | rx_pop;
    assign rx_push   = in_valid & in_ready;
    assign out_valid = ~tx_empty;
    assign tx_pop    = out_valid & out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (in_data),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .wdata (io_wdata),
        .pop   (tx_pop),
        .rdata (out_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

endmodule

// File: tb/tb_io_fifo_port.sv
// Self-checking bench for io_fifo_port: directed scenarios followed by random
// traffic, all compared against a queue-based transaction model.
module tb_io_fifo_port;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             io_read;
    logic             io_write;
    logic [WIDTH-1:0] io_wdata;
    logic [WIDTH-1:0] io_rdata;
    logic             ioack;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       rx_count;
    logic [2:0]       tx_count;

    io_fifo_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .ioack     (ioack),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rx_count  (rx_count),
        .tx_count  (tx_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction model: FIFO contents as queues, plus whether an ack is showing
    // and whether the current request was already served and must be dropped.
    logic [WIDTH-1:0] m_rx[$];
    logic [WIDTH-1:0] m_tx[$];
    logic             m_ack;
    logic             m_served;
    logic [WIDTH-1:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rx.delete();
        m_tx.delete();
        m_ack    = 1'b0;
        m_served = 1'b0;
        m_rdata  = '0;
    endtask

    function automatic logic model_can_pop();
        return !m_ack && !m_served && io_read && (m_rx.size() > 0);
    endfunction

    task automatic model_edge();
        logic can_serve, c_pop, c_push, d_push, d_pop;
        if (!reset) begin
            model_clear();
            return;
        end
        can_serve = !m_ack && !m_served;
        c_pop     = model_can_pop();
        c_push    = can_serve && !io_read && io_write && (m_tx.size() < DEPTH);
        d_push    = in_valid && ((m_rx.size() < DEPTH) || c_pop);
        d_pop     = out_ready && (m_tx.size() > 0);
        m_served  = m_ack || (m_served && (io_read || io_write));
        m_ack     = c_pop || c_push;
        if (c_pop) m_rdata = m_rx.pop_front();
        if (d_pop) void'(m_tx.pop_front());
        if (c_push) m_tx.push_back(io_wdata);
        if (d_push) m_rx.push_back(in_data);
    endtask

    task automatic compare_all();
        check_eq("ioack", ioack, m_ack);
        check_eq("io_rdata", io_rdata, m_rdata);
        check_eq("rx_count", rx_count, m_rx.size());
        check_eq("tx_count", tx_count, m_tx.size());
        check_eq("out_valid", out_valid, m_tx.size() > 0);
        check_eq("in_ready", in_ready, (m_rx.size() < DEPTH) || model_can_pop());
        if (m_tx.size() > 0) check_eq("out_data", out_data, m_tx[0]);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic core_write(input logic [WIDTH-1:0] w);
        io_write = 1'b1;
        io_wdata = w;
        step();
        check_eq("write_ack", ioack, 1'b1);
        io_write = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: run still active, expected finish before 1000000 ns");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acks;
        logic req_on, acked;
        int kind;
        logic [WIDTH-1:0] exp_word;

        reset = 1'b0; io_read = 1'b0; io_write = 1'b0; io_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        step();
        check_eq("rst_ioack", ioack, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b1;
        step();

        // Write then drain
        io_write = 1'b1; io_wdata = 16'hBEEF;
        step();
        check_eq("wd_ack", ioack, 1'b1);
        check_eq("wd_txcnt", tx_count, 3'd1);
        check_eq("wd_data", out_data, 16'hBEEF);
        io_write = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        check_eq("wd_drained", tx_count, 3'd0);
        out_ready = 1'b0;
        step();

        // Blocking read
        io_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("br_stall", ioack, 1'b0);
        end
        in_valid = 1'b1; in_data = 16'h1234;
        step();
        check_eq("br_push_noack", ioack, 1'b0);
        in_valid = 1'b0;
        step();
        check_eq("br_ack", ioack, 1'b1);
        check_eq("br_rdata", io_rdata, 16'h1234);
        io_read = 1'b0;
        step();
        step();

        // Full TX: four writes, fifth stalls until one word leaves
        for (int k = 1; k <= 4; k++) core_write(WIDTH'(k));
        io_write = 1'b1; io_wdata = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("ft_stall", ioack, 1'b0);
        end
        check_eq("ft_full", tx_count, 3'd4);
        check_eq("ft_head", out_data, 16'h0001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check_eq("ft_ack5", ioack, 1'b1);
        io_write = 1'b0;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            exp_word = WIDTH'(k);
            check_eq("ft_order", out_data, exp_word);
            step();
        end
        out_ready = 1'b0;
        check_eq("ft_empty", tx_count, 3'd0);
        step();

        // Held read is served exactly once
        in_valid = 1'b1; in_data = 16'hAAAA;
        step();
        in_data = 16'hBBBB;
        step();
        in_valid = 1'b0;
        io_read = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ioack) acks++;
        end
        check_eq("hold_acks", acks, 1);
        check_eq("hold_rdata", io_rdata, 16'hAAAA);
        check_eq("hold_rxcnt", rx_count, 3'd1);
        io_read = 1'b0;
        step();
        step();

        // Read wins over a simultaneous write
        io_read = 1'b1;
        step();
        io_read = 1'b0;
        step();
        step();
        in_valid = 1'b1; in_data = 16'h0042;
        step();
        in_valid = 1'b0;
        io_read = 1'b1; io_write = 1'b1; io_wdata = 16'h7777;
        step();
        check_eq("rw_ack", ioack, 1'b1);
        check_eq("rw_rdata", io_rdata, 16'h0042);
        check_eq("rw_txcnt", tx_count, 3'd0);
        step();
        step();
        check_eq("rw_txcnt_held", tx_count, 3'd0);
        io_read = 1'b0; io_write = 1'b0;
        step();
        step();

        // Reset while a write is stalled on a full TX
        for (int k = 0; k < 4; k++) core_write(16'hC000 | WIDTH'(k));
        io_write = 1'b1; io_wdata = 16'hD00D;
        step();
        step();
        check_eq("rs_stall", ioack, 1'b0);
        reset = 1'b0;
        model_clear();
        #2;
        check_eq("rs_ioack", ioack, 1'b0);
        check_eq("rs_txcnt", tx_count, 3'd0);
        check_eq("rs_outvalid", out_valid, 1'b0);
        compare_all();
        step();
        reset = 1'b1;
        step();
        check_eq("rs_reack", ioack, 1'b1);
        check_eq("rs_txcnt1", tx_count, 3'd1);
        io_write = 1'b0;
        step();
        step();

        // Random traffic
        req_on = 1'b0;
        acked  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!req_on) begin
                if ($urandom_range(0, 3) == 0) begin
                    kind     = int'($urandom_range(0, 2));
                    io_read  = (kind != 1);
                    io_write = (kind != 0);
                    io_wdata = WIDTH'($urandom);
                    req_on   = 1'b1;
                    acked    = 1'b0;
                end
            end else begin
                if (m_ack) acked = 1'b1;
                if (acked && ($urandom_range(0, 2) == 0)) begin
                    io_read  = 1'b0;
                    io_write = 1'b0;
                    req_on   = 1'b0;
                end
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = WIDTH'($urandom);
            if (((i / 150) % 2) == 0) out_ready = ($urandom_range(0, 4) == 0);
            else out_ready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                model_clear();
                #2;
                compare_all();
                step();
                reset = 1'b1;
                acked = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
